// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the matrix-processor sequencer.
//   - opcode values carried in the instruction word
//   - bit position of the opcode field inside the instruction word
//   - sequencer state encoding
//   - helper that maps an opcode to the number of result words it returns
package proc_pkg;

  // Opcode field position inside the instruction word
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 29;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_TRANS = 3'd3,
    OP_DEL   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE_I = 3'd2,
    ST_ISSUE_D = 3'd3,
    ST_WAIT    = 3'd4,
    ST_WB      = 3'd5,
    ST_DRAIN   = 3'd6
  } state_e;

  // The determinant returns a single word; every other opcode (including the
  // undefined ones 5..7) occupies a full four-word writeback.
  function automatic logic [2:0] rcnt_of(input logic [2:0] op);
    if (op == OP_DEL) begin
      rcnt_of = 3'd1;
    end else begin
      rcnt_of = 3'd4;
    end
  endfunction

endpackage

// File: rtl/proc_job_buf.sv
// proc_job_buf: small register file with one write port and one
// combinational read port. Contents are not reset.
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write index
//   i_wdata  in   write data
//   i_raddr  in   read index
//   o_rdata  out  word at i_raddr (0 when i_raddr is past the last entry)
module proc_job_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  generate
    if (DEPTH == (1 << AW)) begin : g_full
      // Storage write; every index is a real entry
      always_ff @(posedge clk) begin
        if (i_we) begin
          r_mem[i_waddr] <= i_wdata;
        end
      end

      // Read port
      always_comb begin
        o_rdata = r_mem[i_raddr];
      end
    end else begin : g_part
      localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

      // Storage write; indices past the last entry are dropped
      always_ff @(posedge clk) begin
        if (i_we && (i_waddr <= LAST_IDX)) begin
          r_mem[i_waddr] <= i_wdata;
        end
      end

      // Read port; indices past the last entry read as zero
      always_comb begin
        o_rdata = '0;
        if (i_raddr <= LAST_IDX) begin
          o_rdata = r_mem[i_raddr];
        end else begin
          o_rdata = '0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: upstream sequencer for the matrix processor stage.
// Buffers one job (instruction + NUM_DATA operands) from a valid/ready
// stream, replays it to the processor as contiguous en_inst/en_data bursts,
// waits WAIT_CYC idle cycles, collects results with en_wb and presents them
// on a valid/ready stream with last/err flags. All outputs are registered.
//   clk, rst                   clock, synchronous active-high reset
//   s_valid/s_ready/s_data     job word input stream
//   m_valid/m_ready/m_data     result word output stream
//   m_last, m_err              final word of job / opcode above OP_DEL
//   busy                       not idle
//   p_data_in, p_en_inst, p_en_data, p_en_wb   processor drive
//   p_data_out                 processor result, sampled during en_wb
module proc_seq_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_err,
  output logic              busy,
  output logic [DATA_W-1:0] p_data_in,
  output logic              p_en_inst,
  output logic              p_en_data,
  output logic              p_en_wb,
  input  logic [DATA_W-1:0] p_data_out
);

  localparam int IB_DEPTH = NUM_DATA + 1;
  localparam int IB_AW    = $clog2(IB_DEPTH);
  localparam int OB_DEPTH = 4;
  localparam int OB_AW    = 2;
  // Shared phase counter must reach NUM_DATA-1 and WAIT_CYC-1 (at most 14)
  localparam int KW       = $clog2((NUM_DATA > 16) ? NUM_DATA : 16);

  localparam logic [IB_AW-1:0] FCNT_LAST   = IB_AW'(NUM_DATA);
  localparam logic [KW-1:0]    K_DATA_LAST = KW'(NUM_DATA - 1);
  localparam logic [KW-1:0]    K_WAIT_LAST = KW'(WAIT_CYC - 1);

  state_e              r_state;
  logic [IB_AW-1:0]    r_fcnt;
  logic [KW-1:0]       r_k;
  logic [OB_AW-1:0]    r_j;
  logic [2:0]          r_rcnt;
  logic [2:0]          r_op;
  logic                r_s_ready;
  logic                r_busy;
  logic [DATA_W-1:0]   r_p_data_in;
  logic                r_p_en_inst;
  logic                r_p_en_data;
  logic                r_p_en_wb;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_m_last;
  logic                r_m_err;

  state_e              w_state_nxt;
  logic [IB_AW-1:0]    w_fcnt_nxt;
  logic [KW-1:0]       w_k_nxt;
  logic [OB_AW-1:0]    w_j_nxt;
  logic                w_s_acc;
  logic                w_m_acc;
  logic                w_ib_we;
  logic [IB_AW-1:0]    w_ib_waddr;
  logic [IB_AW-1:0]    w_ib_raddr;
  logic [DATA_W-1:0]   w_ib_rdata;
  logic                w_ob_we;
  logic [OB_AW-1:0]    w_ob_waddr;
  logic [DATA_W-1:0]   w_ob_rdata;
  logic [OB_AW-1:0]    w_r_last;
  logic [DATA_W-1:0]   w_p_data_in_nxt;
  logic [DATA_W-1:0]   w_m_data_nxt;
  logic                w_m_last_nxt;

  assign w_s_acc    = s_valid && r_s_ready;
  assign w_m_acc    = r_m_valid && m_ready;
  assign w_ob_waddr = r_k[OB_AW-1:0];
  // Index of the final result word: 0 for one word, 3 for four words
  assign w_r_last   = OB_AW'(r_rcnt - 3'd1);

  proc_job_buf #(.DATA_W(DATA_W), .DEPTH(IB_DEPTH), .AW(IB_AW)) u_ibuf (
    .clk     (clk),
    .i_we    (w_ib_we),
    .i_waddr (w_ib_waddr),
    .i_wdata (s_data),
    .i_raddr (w_ib_raddr),
    .o_rdata (w_ib_rdata)
  );

  proc_job_buf #(.DATA_W(DATA_W), .DEPTH(OB_DEPTH), .AW(OB_AW)) u_obuf (
    .clk     (clk),
    .i_we    (w_ob_we),
    .i_waddr (w_ob_waddr),
    .i_wdata (p_data_out),
    .i_raddr (w_j_nxt),
    .o_rdata (w_ob_rdata)
  );

  // Next-state, counter and buffer-write decode
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_k_nxt     = r_k;
    w_j_nxt     = r_j;
    w_ib_we     = 1'b0;
    w_ib_waddr  = r_fcnt;
    w_ob_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s_acc) begin
          w_ib_we     = 1'b1;
          w_ib_waddr  = '0;
          w_fcnt_nxt  = IB_AW'(1);
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (w_s_acc) begin
          w_ib_we = 1'b1;
          if (r_fcnt == FCNT_LAST) begin
            w_fcnt_nxt  = '0;
            w_state_nxt = ST_ISSUE_I;
          end else begin
            w_fcnt_nxt  = r_fcnt + IB_AW'(1);
          end
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_ISSUE_I: begin
        w_k_nxt     = '0;
        w_state_nxt = ST_ISSUE_D;
      end
      ST_ISSUE_D: begin
        if (r_k == K_DATA_LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = ST_WAIT;
        end else begin
          w_k_nxt     = r_k + KW'(1);
        end
      end
      ST_WAIT: begin
        if (r_k == K_WAIT_LAST) begin
          w_k_nxt     = '0;
          w_state_nxt = ST_WB;
        end else begin
          w_k_nxt     = r_k + KW'(1);
        end
      end
      ST_WB: begin
        w_ob_we = 1'b1;
        if (r_k == KW'(w_r_last)) begin
          w_k_nxt     = '0;
          w_j_nxt     = '0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_k_nxt     = r_k + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (w_m_acc) begin
          if (r_j == w_r_last) begin
            w_j_nxt     = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_j_nxt     = r_j + OB_AW'(1);
          end
        end else begin
          w_j_nxt = r_j;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Values the registered outputs take in the coming state
  always_comb begin
    w_ib_raddr      = '0;
    w_p_data_in_nxt = '0;
    w_m_data_nxt    = '0;
    w_m_last_nxt    = 1'b0;
    // Operand k of the burst lives at ibuf[1+k]; the instruction at ibuf[0]
    if (w_state_nxt == ST_ISSUE_D) begin
      w_ib_raddr = IB_AW'(w_k_nxt) + IB_AW'(1);
    end else begin
      w_ib_raddr = '0;
    end
    if ((w_state_nxt == ST_ISSUE_I) || (w_state_nxt == ST_ISSUE_D)) begin
      w_p_data_in_nxt = w_ib_rdata;
    end else begin
      w_p_data_in_nxt = '0;
    end
    if (w_state_nxt == ST_DRAIN) begin
      // On the last WB edge the word being captured may be the one to present
      if (w_ob_we && (w_ob_waddr == w_j_nxt)) begin
        w_m_data_nxt = p_data_out;
      end else begin
        w_m_data_nxt = w_ob_rdata;
      end
      w_m_last_nxt = (w_j_nxt == w_r_last);
    end else begin
      w_m_data_nxt = '0;
      w_m_last_nxt = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fcnt      <= '0;
      r_k         <= '0;
      r_j         <= '0;
      r_rcnt      <= 3'd0;
      r_op        <= 3'd0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_p_data_in <= '0;
      r_p_en_inst <= 1'b0;
      r_p_en_data <= 1'b0;
      r_p_en_wb   <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_m_err     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_k         <= w_k_nxt;
      r_j         <= w_j_nxt;
      // During ISSUE_I the registered p_data_in holds the instruction word
      if (r_state == ST_ISSUE_I) begin
        r_op   <= r_p_data_in[OP_MSB:OP_LSB];
        r_rcnt <= rcnt_of(r_p_data_in[OP_MSB:OP_LSB]);
      end
      r_s_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FETCH);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_p_data_in <= w_p_data_in_nxt;
      r_p_en_inst <= (w_state_nxt == ST_ISSUE_I);
      r_p_en_data <= (w_state_nxt == ST_ISSUE_D);
      r_p_en_wb   <= (w_state_nxt == ST_WB);
      r_m_valid   <= (w_state_nxt == ST_DRAIN);
      r_m_data    <= w_m_data_nxt;
      r_m_last    <= w_m_last_nxt;
      r_m_err     <= (w_state_nxt == ST_DRAIN) && (r_op > OP_DEL);
    end
  end

  assign s_ready   = r_s_ready;
  assign busy      = r_busy;
  assign p_data_in = r_p_data_in;
  assign p_en_inst = r_p_en_inst;
  assign p_en_data = r_p_en_data;
  assign p_en_wb   = r_p_en_wb;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign m_err     = r_m_err;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Testbench for proc_seq_ctrl: table-driven jobs with constant expectations,
// hand-written backpressure and reset sequences, and random jobs checked
// against a matrix-arithmetic reference model. A behavioural processor model
// answers en_inst/en_data/en_wb.
module tb_proc_seq_ctrl;

  localparam int NUM_DATA = 8;
  localparam int WAIT_CYC = 1;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last, m_err, busy;
  logic [31:0] m_data, p_data_in, p_data_out;
  logic        p_en_inst, p_en_data, p_en_wb;

  int checks = 0;
  int errors = 0;

  proc_seq_ctrl #(.DATA_W(32), .NUM_DATA(NUM_DATA), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_err(m_err), .busy(busy),
    .p_data_in(p_data_in), .p_en_inst(p_en_inst), .p_en_data(p_en_data),
    .p_en_wb(p_en_wb), .p_data_out(p_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 2x2 matrices A = v[0..3], B = v[4..7], row-major
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [7:0][31:0] v,
                                             input int idx);
    int r, c;
    r = idx / 2;
    c = idx % 2;
    if (idx < 0 || idx > 3) return 32'h0;
    case (op)
      3'd0: return v[idx] + v[4 + idx];
      3'd1: return v[idx] - v[4 + idx];
      3'd2: return v[2*r] * v[4 + c] + v[2*r + 1] * v[6 + c];
      3'd3: return v[2*c + r];
      3'd4: return (idx == 0) ? (v[0] * v[3] - v[1] * v[2]) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural processor: write index resets whenever enables drop
  logic [2:0]       pm_op;
  logic [7:0][31:0] pm_mem;
  int               pm_w, pm_r;
  always @(posedge clk) begin
    if (rst) begin
      pm_w <= 0;
      pm_r <= 0;
    end else begin
      if (p_en_inst) begin
        pm_op <= p_data_in[31:29];
        pm_w  <= 0;
      end else if (p_en_data) begin
        if (pm_w < 8) pm_mem[pm_w] <= p_data_in;
        pm_w <= pm_w + 1;
      end else begin
        pm_w <= 0;
      end
      if (p_en_wb) pm_r <= pm_r + 1;
      else         pm_r <= 0;
    end
  end
  assign p_data_out = (pm_r < 4) ? ref_result(pm_op, pm_mem, pm_r) : 32'h0BAD0BAD;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Processor-side protocol monitor
  task automatic monitor();
    int run_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
      end else begin
        if (p_en_inst | p_en_data | p_en_wb)
          chk("en_onehot", 128'($countones({p_en_inst, p_en_data, p_en_wb})), 128'd1);
        if (!p_en_inst && !p_en_data)
          chk("pdin_idle", 128'(p_data_in), 128'd0);
        if (p_en_data) begin
          run_len++;
        end else if (run_len != 0) begin
          chk("data_burst_len", 128'(run_len), 128'(NUM_DATA));
          run_len = 0;
        end
      end
    end
  endtask

  // Send one job; smode 1 inserts an idle cycle before every word after the first
  task automatic send_job(input logic [8:0][31:0] w, input int smode);
    int tmo;
    for (int i = 0; i < 9; i++) begin
      if (smode == 1 && i > 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = w[i];
      tmo = 0;
      while (!s_ready && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 50) begin
        chk("s_ready_timeout", 128'(i), 128'd99);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_data  = 32'h0;
  endtask

  // Collect results; rmode 0 always ready, 1 random, 2 five-cycle stall on word 1
  task automatic collect(input logic [3:0][31:0] e, input int n, input bit err, input int rmode);
    int lat, j, cyc, stall;
    bit rdy, held;
    logic [33:0] held_word;
    chk("busy_in_job", 128'(busy), 128'd1);
    lat = 0;
    while (!m_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("first_result_latency", 128'(lat), 128'(1 + NUM_DATA + WAIT_CYC + n));
    if (lat >= 300) return;
    j = 0; cyc = 0; stall = 0; held = 1'b0; held_word = '0;
    while (j < n && cyc < 400) begin
      cyc++;
      if (!m_valid) begin
        chk("m_valid_mid_drain", 128'(m_valid), 128'd1);
        break;
      end
      if (held) chk("hold_stable", 128'({m_data, m_last, m_err}), 128'(held_word));
      case (rmode)
        1: rdy = 1'($urandom_range(0, 1));
        2: begin
          rdy = !(j == 1 && stall < 5);
          if (!rdy) stall++;
        end
        default: rdy = 1'b1;
      endcase
      m_ready = rdy;
      if (rdy) begin
        chk($sformatf("result_word%0d", j), 128'({m_data, m_last, m_err}),
            128'({e[j], (j == n - 1), err}));
        j++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        held_word = {m_data, m_last, m_err};
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    if (j < n) chk("drain_timeout", 128'(j), 128'(n));
    chk("idle_after_drain", 128'({m_valid, busy}), 128'd0);
  endtask

  task automatic run_job(input logic [8:0][31:0] w, input logic [3:0][31:0] e,
                         input int n, input bit err, input int smode, input int rmode);
    send_job(w, smode);
    collect(e, n, err, rmode);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({s_ready, m_valid, m_data, m_last, m_err, busy,
                 p_data_in, p_en_inst, p_en_data, p_en_wb});
  endfunction

  typedef struct packed {
    logic [8:0][31:0] w;
    logic [3:0][31:0] e;
    logic [2:0]       n;
    logic             err;
    logic [1:0]       smode;
    logic [1:0]       rmode;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [2:0]       op;
    logic [7:0][31:0] ops;
    logic [8:0][31:0] w;
    logic [3:0][31:0] e;

    rst = 1'b1; s_valid = 1'b0; s_data = 32'h0; m_ready = 1'b0;

    // add / mul (gapped fetch) / del / invalid opcode (stalled drain)
    vecs[0].w = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'h00000000};
    vecs[0].e = {32'd12, 32'd10, 32'd8, 32'd6};
    vecs[0].n = 3'd4; vecs[0].err = 1'b0; vecs[0].smode = 2'd0; vecs[0].rmode = 2'd0;
    vecs[1].w = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'h40000000};
    vecs[1].e = {32'd50, 32'd43, 32'd22, 32'd19};
    vecs[1].n = 3'd4; vecs[1].err = 1'b0; vecs[1].smode = 2'd1; vecs[1].rmode = 2'd0;
    vecs[2].w = {32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd1, 32'd2, 32'd3, 32'h80000000};
    vecs[2].e = {32'd0, 32'd0, 32'd0, 32'd10};
    vecs[2].n = 3'd1; vecs[2].err = 1'b0; vecs[2].smode = 2'd0; vecs[2].rmode = 2'd0;
    vecs[3].w = {{8{32'd9}}, 32'hE0000000};
    vecs[3].e = {32'd0, 32'd0, 32'd0, 32'd0};
    vecs[3].n = 3'd4; vecs[3].err = 1'b1; vecs[3].smode = 2'd0; vecs[3].rmode = 2'd2;

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'd0);
    rst = 1'b0;
    fork
      monitor();
    join_none

    for (int i = 0; i < 4; i++)
      run_job(vecs[i].w, vecs[i].e, int'(vecs[i].n), vecs[i].err,
              int'(vecs[i].smode), int'(vecs[i].rmode));

    // Gapped fetch together with a stalled drain on the same job
    run_job(vecs[0].w, vecs[0].e, 4, 1'b0, 1, 2);

    // Reset in the second WB cycle, then a fresh add job
    send_job(vecs[0].w, 0);
    t = 0;
    while (!p_en_wb && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wb_reached", 128'(p_en_wb), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_wb_outputs", all_outs(), 128'd0);
    rst = 1'b0;
    run_job(vecs[0].w, vecs[0].e, 4, 1'b0, 0, 0);

    // Random jobs against the reference model
    for (int r = 0; r < 8; r++) begin
      op = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) ops[k] = $urandom;
      w = {ops, op, 29'($urandom)};
      for (int k = 0; k < 4; k++) e[k] = ref_result(op, ops, k);
      run_job(w, e, (op == 3'd4) ? 1 : 4, (op > 3'd4), int'($urandom_range(0, 1)), 1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
